fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 134 +++++++++++++
 tb/tb_fetch_decode.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage: a programmable instruction memory, a
// program counter sequenced by an IDLE/RUN/HALT controller, and a
// combinational decoder for the addi and bne instructions.
module fetch_decode #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADD_WIDTH      = 5,
  parameter int ROM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [ROM_ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0]     prog_data,
  input  logic                      start,
  input  logic                      EQ,
  output logic [ADD_WIDTH-1:0]      AD1,
  output logic [ADD_WIDTH-1:0]      AD2,
  output logic [ADD_WIDTH-1:0]      AD3,
  output logic                      WE3,
  output logic                      ALUsrc,
  output logic [DATA_WIDTH-1:0]     Immop,
  output logic [DATA_WIDTH-1:0]     PC,
  output logic [DATA_WIDTH-1:0]     instr,
  output logic                      running,
  output logic                      illegal
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] mem [2**ROM_ADDR_WIDTH];

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  is_addi;
  logic                  is_bne;
  logic                  stop;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] pc_sum;
  logic [DATA_WIDTH-1:0] pc_step;

  // Fetch: word-indexed asynchronous read; PC bits above the memory alias.
  assign instr = mem[PC[ROM_ADDR_WIDTH+1:2]];

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign is_addi = (opcode == OP_ADDI) && (funct3 == 3'b000);
  assign is_bne  = (opcode == OP_BNE)  && (funct3 == 3'b001);
  // A zero word and any unsupported word both stop execution.
  assign stop    = !(is_addi || is_bne);

  assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};

  assign AD1 = ADD_WIDTH'(instr[19:15]);
  assign AD2 = ADD_WIDTH'(instr[24:20]);
  assign AD3 = ADD_WIDTH'(instr[11:7]);

  assign running = (state == RUN);

  // Decode control signals; register writes are only allowed while running.
  always_comb begin
    WE3    = 1'b0;
    ALUsrc = 1'b0;
    Immop  = '0;
    if (is_addi) begin
      WE3    = (state == RUN);
      ALUsrc = 1'b1;
      Immop  = imm_i;
    end else if (is_bne) begin
      Immop  = imm_b;
    end
  end

  // Next PC: taken branch adds the offset, otherwise sequential; word-aligned.
  assign pc_sum  = (is_bne && !EQ) ? (PC + Immop) : (PC + DATA_WIDTH'(4));
  assign pc_step = {pc_sum[DATA_WIDTH-1:2], 2'b00};

  // Controller next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (stop)  state_next = HALT;
      HALT:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // PC and sticky illegal flag; PC holds on the edge that halts.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!stop)              PC      <= pc_step;
          else if (instr != '0)   illegal <= 1'b1;
        end
        HALT: begin
          if (start) begin
            PC      <= '0;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Program load port; ignored while running and while in reset.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && (state != RUN)) mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode.
module tb_fetch_decode;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        EQ;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3, ALUsrc, running, illegal;
  logic [31:0] Immop, PC, instr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_decode #(.DATA_WIDTH(32), .ADD_WIDTH(5), .ROM_ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .EQ(EQ),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc),
    .Immop(Immop), .PC(PC), .instr(instr), .running(running),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; EQ = 1'b0;
    step();
    check("rst_pc", PC, 32'h0);
    check("rst_running", {31'b0, running}, 32'h0);
    check("rst_we3", {31'b0, WE3}, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'h0);
    rst = 1'b0;

    load(8'd0, 32'h00500513);
    load(8'd1, 32'hFFF08093);
    load(8'd2, 32'hFE009EE3);
    load(8'd3, 32'h00000000);
    check("idle_running", {31'b0, running}, 32'h0);
    check("idle_we3", {31'b0, WE3}, 32'h0);

    // addi x10, x0, 5
    start = 1'b1; step(); start = 1'b0;
    check("addi_running", {31'b0, running}, 32'h1);
    check("addi_pc", PC, 32'h0);
    check("addi_ad1", {27'b0, AD1}, 32'd0);
    check("addi_ad3", {27'b0, AD3}, 32'd10);
    check("addi_we3", {31'b0, WE3}, 32'h1);
    check("addi_alusrc", {31'b0, ALUsrc}, 32'h1);
    check("addi_imm", Immop, 32'h00000005);

    // addi x1, x1, -1
    step();
    check("neg_pc", PC, 32'h4);
    check("neg_imm", Immop, 32'hFFFFFFFF);
    check("neg_ad1", {27'b0, AD1}, 32'd1);
    check("neg_ad3", {27'b0, AD3}, 32'd1);
    check("neg_we3", {31'b0, WE3}, 32'h1);

    // bne x1, x0, -4
    step();
    check("bne_pc", PC, 32'h8);
    check("bne_ad1", {27'b0, AD1}, 32'd1);
    check("bne_ad2", {27'b0, AD2}, 32'd0);
    check("bne_we3", {31'b0, WE3}, 32'h0);
    check("bne_alusrc", {31'b0, ALUsrc}, 32'h0);
    check("bne_imm", Immop, 32'hFFFFFFFC);
    EQ = 1'b0;
    step();
    check("bne_taken_pc", PC, 32'h4);
    step();
    check("bne_again_pc", PC, 32'h8);
    EQ = 1'b1;
    step();
    check("bne_nottaken_pc", PC, 32'hC);
    check("zero_running", {31'b0, running}, 32'h1);
    check("zero_we3", {31'b0, WE3}, 32'h0);

    // start and a write while running must both be ignored
    start = 1'b1; prog_we = 1'b1; prog_addr = 8'd3; prog_data = 32'h00000013;
    step();
    start = 1'b0; prog_we = 1'b0;
    check("halt_running", {31'b0, running}, 32'h0);
    check("halt_pc", PC, 32'hC);
    check("halt_illegal", {31'b0, illegal}, 32'h0);
    check("run_write_ignored", instr, 32'h0);
    step();
    check("halt_pc_hold", PC, 32'hC);
    check("halt_we3", {31'b0, WE3}, 32'h0);

    // extend program in HALT, rerun to PC=0x10 then reset mid-run
    load(8'd3, 32'h00500513);
    load(8'd4, 32'h00000000);
    start = 1'b1; step(); start = 1'b0;
    check("restart_pc", PC, 32'h0);
    check("restart_running", {31'b0, running}, 32'h1);
    step(); step();
    check("rerun_pc8", PC, 32'h8);
    EQ = 1'b1;
    step();
    check("halt_write_instr", instr, 32'h00500513);
    check("halt_write_we3", {31'b0, WE3}, 32'h1);
    step();
    check("mid_pc", PC, 32'h10);
    check("mid_running", {31'b0, running}, 32'h1);
    rst = 1'b1; start = 1'b1;
    step();
    check("abort_pc", PC, 32'h0);
    check("abort_running", {31'b0, running}, 32'h0);
    check("abort_we3", {31'b0, WE3}, 32'h0);
    step();
    check("rst_over_start", {31'b0, running}, 32'h0);
    rst = 1'b0;
    step(); start = 1'b0;
    check("retain_running", {31'b0, running}, 32'h1);
    check("retain_pc", PC, 32'h0);
    check("retain_instr", instr, 32'h00500513);

    // unsupported opcode, written on the same edge as start
    rst = 1'b1; step(); rst = 1'b0;
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'h00000033; start = 1'b1;
    step();
    prog_we = 1'b0; start = 1'b0;
    check("same_edge_instr", instr, 32'h00000033);
    check("same_edge_running", {31'b0, running}, 32'h1);
    check("bad_we3", {31'b0, WE3}, 32'h0);
    step();
    check("bad_running", {31'b0, running}, 32'h0);
    check("bad_illegal", {31'b0, illegal}, 32'h1);
    check("bad_pc", PC, 32'h0);
    step();
    check("illegal_sticky", {31'b0, illegal}, 32'h1);
    start = 1'b1; step(); start = 1'b0;
    check("illegal_clr_run", {31'b0, illegal}, 32'h0);
    check("illegal_clr_running", {31'b0, running}, 32'h1);
    step();
    check("illegal_reset", {31'b0, illegal}, 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    check("illegal_rst_clr", {31'b0, illegal}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
